// File: rtl/seq_mult_nxn.sv
// Sequential WxW multiplier: one 4x4 nibble partial product per cycle over K*K steps,
// operating on magnitudes with a final sign-fix step for two's-complement mode.
module seq_mult_nxn #(
   parameter int W = 8
) (
   input  logic             clk,
   input  logic             reset_n,
   input  logic             start,
   input  logic             signed_mode,
   input  logic [W-1:0]     dataa,
   input  logic [W-1:0]     datab,
   output logic             busy,
   output logic             done,
   output logic [2*W-1:0]   product
);

   localparam int K  = W / 4;
   localparam int N  = K * K;
   localparam int CW = (N > 1) ? $clog2(N) : 1;

   if ((W % 4) != 0 || W < 4) begin : g_bad_width
      $error("seq_mult_nxn: W must be a multiple of 4 and at least 4");
   end

   typedef enum logic [1:0] {IDLE, CALC, FIX, DONE} state_t;

   state_t            state_q, state_d;
   logic [W-1:0]      a_q, a_d;
   logic [W-1:0]      b_q, b_d;
   logic              neg_q, neg_d;
   logic [2*W-1:0]    acc_q, acc_d;
   logic [CW-1:0]     cnt_q, cnt_d;
   logic              busy_q, busy_d;
   logic              done_q, done_d;
   logic [2*W-1:0]    product_q, product_d;

   int                idx_i_s;
   int                idx_j_s;
   logic [7:0]        nib_prod_s;
   logic [2*W-1:0]    term_s;

   // next-state, datapath step and output decode
   always_comb begin
      state_d   = state_q;
      a_d       = a_q;
      b_d       = b_q;
      neg_d     = neg_q;
      acc_d     = acc_q;
      cnt_d     = cnt_q;
      product_d = product_q;

      idx_i_s    = int'(cnt_q) % K;
      idx_j_s    = int'(cnt_q) / K;
      nib_prod_s = {4'b0000, a_q[4*idx_i_s +: 4]} * {4'b0000, b_q[4*idx_j_s +: 4]};
      term_s     = (2*W)'(nib_prod_s) << (4 * (idx_i_s + idx_j_s));

      case (state_q)
         IDLE, DONE: begin
            if (start) begin
               // magnitudes are stored unsigned so -2^(W-1) maps to 2^(W-1) without loss
               a_d     = (signed_mode && dataa[W-1]) ? (~dataa + W'(1)) : dataa;
               b_d     = (signed_mode && datab[W-1]) ? (~datab + W'(1)) : datab;
               neg_d   = signed_mode & (dataa[W-1] ^ datab[W-1]);
               acc_d   = '0;
               cnt_d   = '0;
               state_d = CALC;
            end else begin
               state_d = IDLE;
            end
         end
         CALC: begin
            acc_d = acc_q + term_s;
            if (cnt_q == CW'(N - 1)) begin
               state_d = FIX;
            end else begin
               cnt_d = cnt_q + CW'(1);
            end
         end
         FIX: begin
            product_d = neg_q ? (~acc_q + (2*W)'(1)) : acc_q;
            state_d   = DONE;
         end
         default: begin
            state_d = IDLE;
         end
      endcase

      busy_d = (state_d == CALC) || (state_d == FIX);
      done_d = (state_d == DONE);
   end

   // state and output registers with synchronous active-low reset
   always_ff @(posedge clk) begin
      if (!reset_n) begin
         state_q   <= IDLE;
         a_q       <= '0;
         b_q       <= '0;
         neg_q     <= 1'b0;
         acc_q     <= '0;
         cnt_q     <= '0;
         busy_q    <= 1'b0;
         done_q    <= 1'b0;
         product_q <= '0;
      end else begin
         state_q   <= state_d;
         a_q       <= a_d;
         b_q       <= b_d;
         neg_q     <= neg_d;
         acc_q     <= acc_d;
         cnt_q     <= cnt_d;
         busy_q    <= busy_d;
         done_q    <= done_d;
         product_q <= product_d;
      end
   end

   assign busy    = busy_q;
   assign done    = done_q;
   assign product = product_q;

endmodule

// File: tb/tb_seq_mult_nxn.sv
// Directed self-checking bench for seq_mult_nxn at W=8 and W=16.
module tb_seq_mult_nxn;

   logic        clk = 1'b0;
   logic        reset_n;
   logic        start8, sm8, busy8, done8;
   logic [7:0]  a8, b8;
   logic [15:0] p8;
   logic        start16, sm16, busy16, done16;
   logic [15:0] a16, b16;
   logic [31:0] p16;

   int n_tests = 0;
   int n_fail  = 0;

   always #5 clk = ~clk;

   seq_mult_nxn #(.W(8)) dut8 (
      .clk(clk), .reset_n(reset_n), .start(start8), .signed_mode(sm8),
      .dataa(a8), .datab(b8), .busy(busy8), .done(done8), .product(p8)
   );

   seq_mult_nxn #(.W(16)) dut16 (
      .clk(clk), .reset_n(reset_n), .start(start16), .signed_mode(sm16),
      .dataa(a16), .datab(b16), .busy(busy16), .done(done16), .product(p16)
   );

   task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_tests++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
      end
   endtask

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   function automatic logic cur_done(input bit wide);
      return wide ? done16 : done8;
   endfunction

   function automatic logic cur_busy(input bit wide);
      return wide ? busy16 : busy8;
   endfunction

   function automatic logic [31:0] cur_prod(input bit wide);
      return wide ? p16 : {16'h0000, p8};
   endfunction

   // one operation: latency, busy length, result, single-cycle done
   task automatic run_op(input bit wide, input bit sm, input logic [15:0] a, input logic [15:0] b,
                         input logic [31:0] exp, input int exp_lat, input string tag);
      int lat;
      int bcnt;
      if (wide) begin
         sm16 = sm; a16 = a; b16 = b; start16 = 1'b1;
      end else begin
         sm8 = sm; a8 = a[7:0]; b8 = b[7:0]; start8 = 1'b1;
      end
      tick;
      start8 = 1'b0; start16 = 1'b0;
      a8 = ~a8; b8 = ~b8; a16 = ~a16; b16 = ~b16; sm8 = ~sm8; sm16 = ~sm16;
      lat  = 0;
      bcnt = cur_busy(wide) ? 1 : 0;
      while (!cur_done(wide) && lat < 60) begin
         tick;
         lat++;
         if (cur_busy(wide)) bcnt++;
      end
      check_eq({tag, "_lat"}, 32'(lat), 32'(exp_lat));
      check_eq({tag, "_busy"}, 32'(bcnt), 32'(exp_lat));
      check_eq({tag, "_prod"}, cur_prod(wide), exp);
      tick;
      check_eq({tag, "_done_1cyc"}, {31'd0, cur_done(wide)}, 32'd0);
      check_eq({tag, "_held"}, cur_prod(wide), exp);
   endtask

   initial begin
      int dcount;
      int first;
      int second;
      logic [15:0] pval;
      logic [15:0] p_first;
      logic [15:0] p_second;
      logic [15:0] p_mid;

      reset_n = 1'b0;
      start8 = 1'b0; sm8 = 1'b0; a8 = 8'h00; b8 = 8'h00;
      start16 = 1'b0; sm16 = 1'b0; a16 = 16'h0000; b16 = 16'h0000;
      tick;
      tick;
      check_eq("rst_busy8", {31'd0, busy8}, 32'd0);
      check_eq("rst_done8", {31'd0, done8}, 32'd0);
      check_eq("rst_prod8", {16'h0000, p8}, 32'h0);
      check_eq("rst_prod16", p16, 32'h0);
      reset_n = 1'b1;
      tick;

      run_op(1'b0, 1'b0, 16'h00FF, 16'h00FF, 32'h0000FE01, 5, "u255x255");
      run_op(1'b0, 1'b1, 16'h0080, 16'h0080, 32'h00004000, 5, "s_m128xm128");
      run_op(1'b0, 1'b1, 16'h00FD, 16'h0005, 32'h0000FFF1, 5, "s_m3x5");
      run_op(1'b0, 1'b1, 16'h007F, 16'h0080, 32'h0000C080, 5, "s_127xm128");
      run_op(1'b0, 1'b1, 16'h0000, 16'h00FB, 32'h00000000, 5, "s_0xm5");
      run_op(1'b0, 1'b0, 16'h0000, 16'h0000, 32'h00000000, 5, "u_0x0");

      // start pulsed during CALC must be ignored
      sm8 = 1'b0; a8 = 8'd12; b8 = 8'd13; start8 = 1'b1;
      tick;
      start8 = 1'b0;
      tick;
      a8 = 8'd99; b8 = 8'd77; start8 = 1'b1;
      tick;
      start8 = 1'b0;
      dcount = 0;
      pval = 16'h0000;
      for (int c = 0; c < 15; c++) begin
         tick;
         if (done8) begin
            dcount++;
            pval = p8;
         end
      end
      check_eq("ign_done_cnt", 32'(dcount), 32'd1);
      check_eq("ign_prod", {16'h0000, pval}, 32'h009C);
      check_eq("ign_idle", {31'd0, busy8}, 32'd0);

      // back-to-back: start held across DONE
      sm8 = 1'b0; a8 = 8'd3; b8 = 8'd4; start8 = 1'b1;
      tick;
      first = -1; second = -1;
      p_first = 16'h0; p_second = 16'h0; p_mid = 16'h0;
      for (int c = 1; c <= 30; c++) begin
         tick;
         if (first >= 0 && c == first + 1) start8 = 1'b0;
         if (first >= 0 && c == first + 3) p_mid = p8;
         if (done8) begin
            if (first < 0) begin
               first = c; p_first = p8; a8 = 8'd5; b8 = 8'd6;
            end else if (second < 0) begin
               second = c; p_second = p8;
            end
         end
      end
      start8 = 1'b0;
      check_eq("b2b_first_lat", 32'(first), 32'd5);
      check_eq("b2b_gap", 32'(second - first), 32'd6);
      check_eq("b2b_prod1", {16'h0000, p_first}, 32'd12);
      check_eq("b2b_prod_held", {16'h0000, p_mid}, 32'd12);
      check_eq("b2b_prod2", {16'h0000, p_second}, 32'd30);

      // reset during CALC step 2 aborts the operation
      sm8 = 1'b0; a8 = 8'd200; b8 = 8'd100; start8 = 1'b1;
      tick;
      start8 = 1'b0;
      tick;
      tick;
      reset_n = 1'b0;
      tick;
      reset_n = 1'b1;
      check_eq("abort_busy", {31'd0, busy8}, 32'd0);
      check_eq("abort_done", {31'd0, done8}, 32'd0);
      check_eq("abort_prod", {16'h0000, p8}, 32'h0);
      dcount = 0;
      for (int c = 0; c < 10; c++) begin
         tick;
         if (done8) dcount++;
      end
      check_eq("abort_no_done", 32'(dcount), 32'd0);
      run_op(1'b0, 1'b0, 16'd7, 16'd9, 32'h0000003F, 5, "after_abort_7x9");

      // reset wins over start on the same edge
      reset_n = 1'b0; sm8 = 1'b0; a8 = 8'd1; b8 = 8'd1; start8 = 1'b1;
      tick;
      reset_n = 1'b1; start8 = 1'b0;
      check_eq("rst_prio_busy", {31'd0, busy8}, 32'd0);
      tick;
      check_eq("rst_prio_idle", {31'd0, busy8}, 32'd0);

      run_op(1'b1, 1'b0, 16'hFFFF, 16'hFFFF, 32'hFFFE0001, 17, "w16_uffff");
      run_op(1'b1, 1'b1, 16'h8000, 16'h0001, 32'hFFFF8000, 17, "w16_s8000x1");

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
